reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Read-after-write interlock controller for the 5-stage in-order pipeline.
- Tracks in-flight register writes per architectural register: incremented when an instruction with a destination leaves ID, decremented when WB commits it on the register-file write port.
- Produces the ID-stage stall that gates ID's allow signal, plus debug and error status.
- Sits beside the ID stage; the commit inputs come directly from the WB stage's rf_we/rf_waddr.

Parameters:
- NREG, 32, number of architectural registers (r0 hardwired zero, never tracked).
- AW, 5, register address width.
- CNT_W, 2, per-register pending-count width; CNT_MAX = 2^CNT_W-1 = 3 writes in flight per register.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  AW  source 1 address.
- id_rs1_used  in  1  source 1 is read.
- id_rs2  in  AW  source 2 address.
- id_rs2_used  in  1  source 2 is read.
- id_we  in  1  instruction writes a register.
- id_dest  in  AW  destination address.
- issue_fire  in  1  ID instruction accepted into EX this cycle (valid & allow).
- wb_we  in  1  WB commits a register write (already qualified by WB valid).
- wb_waddr  in  AW  WB write address (zero when wb_we=0).
- flush  in  1  pipeline flush; all younger in-flight writes are cancelled.
- stall_id  out  1  ID must not issue this cycle.
- inflight_total  out  7  total pending writes across all registers.
- sb_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset: every cnt[r]=0, inflight_total=0, sb_err=0. stall_id is combinational, so it reads 0 the cycle after reset.
- Conflict checks:
  - src1 hazard = id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0.
  - src2 hazard = same form for rs2.
  - dest full = id_we & id_dest!=0 & cnt[id_dest]==CNT_MAX.
- stall_id = id_valid & (src1 hazard | src2 hazard | dest full).
  - Uses registered counts only. A WB commit in the same cycle does not clear the stall, because the RF write lands at the edge; the stall releases one cycle later.
- inc = issue_fire & id_we & id_dest!=0. dec = wb_we & wb_waddr!=0.
- Counter update at posedge:
  - cnt[id_dest] += inc; cnt[wb_waddr] -= dec.
  - Same register receiving both in one cycle: net unchanged.
  - Different registers: both updates apply.
- inflight_total updates by +inc -dec in the same cycle and always equals the sum of all cnt[].
- Saturation and errors:
  - Decrement at cnt==0: hold 0, set sb_err.
  - Increment at CNT_MAX: hold CNT_MAX, set sb_err.
  - issue_fire while stall_id=1: perform the update normally, set sb_err.
- flush (priority over inc/dec): at next edge all cnt[] and inflight_total go to 0. Inc and dec presented in the flush cycle are discarded. The pipeline guarantees no surviving write-enabled instruction remains in EX/MEM/WB after a flush.
- Latency: stall_id combinational from ID inputs and cnt; one-cycle count update.
- r0: reads and writes to address 0 never stall and never count.
- sb_err clears only on reset.
- Reset mid-operation overrides flush, inc and dec.

Decomposition:
- Shared package:
  - NREG, AW, CNT_W, CNT_MAX constants.
  - Typedef for reg address.
  - Typedef for count.
- One natural sub-module, sb_counter:
  - One saturating up/down counter with inc, dec, clr inputs and a count output.
  - Drives an overflow/underflow error pulse.
  - Instantiated for r1..r31; top ORs the error pulses into sb_err.

Test Plan:
1. Issue "add r5" (inc), next cycle ID "sub rs1=r5" -> stall_id=1. Stall persists until WB commits r5; stall_id=0 on the cycle after wb_we=1/wb_waddr=5.
2. Same cycle: issue_fire with dest=r7 and wb_we with waddr=r7 while cnt[7]=1 -> cnt[7] stays 1, inflight_total unchanged.
3. Three back-to-back issues to r9 -> cnt[9]=3. A fourth ID instruction with dest r9 gets stall_id=1 and sb_err stays 0. Forcing issue_fire anyway -> cnt holds 3, sb_err=1.
4. Instruction reading r0 and writing r0 with all counts 0 -> stall_id=0, inflight_total stays 0.
5. Two pending writes (r3, r4), then flush with a simultaneous issue to r6 -> next cycle all counts 0, inflight_total=0, ID reading r3 not stalled.
6. wb_we=1, waddr=12 with cnt[12]=0 -> cnt[12] stays 0, sb_err=1. Then reset -> sb_err=0.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package reg_scoreboard_pkg;
  localparam int unsigned NREG    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned TOT_W   = 7;

  typedef logic [AW-1:0]    reg_addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TOT_W-1:0] total_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/WB-side signals of the scoreboard plus its status outputs.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  logic      id_rs1_used;
  reg_addr_t id_rs2;
  logic      id_rs2_used;
  logic      id_we;
  reg_addr_t id_dest;
  logic      issue_fire;
  logic      wb_we;
  reg_addr_t wb_waddr;
  logic      flush;
  logic      stall_id;
  total_t    inflight_total;
  logic      sb_err;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_we, id_dest, issue_fire, wb_we, wb_waddr, flush,
    input  stall_id, inflight_total, sb_err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_we, id_dest, issue_fire, wb_we, wb_waddr, flush,
    output stall_id, inflight_total, sb_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter for one register.
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic up,
  output logic down,
  output logic err
);

  // Effective movement after saturation; inc and dec together cancel.
  always_comb begin
    up   = 1'b0;
    down = 1'b0;
    err  = 1'b0;
    if (!clr) begin
      if (inc && !dec) begin
        if (cnt == cnt_t'(CNT_MAX)) err = 1'b1;
        else                        up  = 1'b1;
      end else if (dec && !inc) begin
        if (cnt == '0) err  = 1'b1;
        else           down = 1'b1;
      end
    end
  end

  // Count register; clear covers both reset and flush.
  always_ff @(posedge clk) begin
    if (clr)       cnt <= '0;
    else if (up)   cnt <= cnt + cnt_t'(1);
    else if (down) cnt <= cnt - cnt_t'(1);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Read-after-write interlock: per-register pending-write counts and ID stall.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);

  cnt_t            cnt [NREG];
  logic [NREG-1:0] up_v;
  logic [NREG-1:0] dn_v;
  logic [NREG-1:0] err_v;
  logic            inc;
  logic            dec;
  logic            clr;
  total_t          total_q;
  logic            err_q;

  assign inc = sb.issue_fire & sb.id_we & (sb.id_dest != '0);
  assign dec = sb.wb_we & (sb.wb_waddr != '0);
  assign clr = reset | sb.flush;

  // r0 is hardwired zero and never tracked.
  assign cnt[0]   = '0;
  assign up_v[0]  = 1'b0;
  assign dn_v[0]  = 1'b0;
  assign err_v[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk  (clk),
      .clr  (clr),
      .inc  (inc && (sb.id_dest == reg_addr_t'(r))),
      .dec  (dec && (sb.wb_waddr == reg_addr_t'(r))),
      .cnt  (cnt[r]),
      .up   (up_v[r]),
      .down (dn_v[r]),
      .err  (err_v[r])
    );
  end

  // Hazard detection from registered counts only.
  always_comb begin
    logic h1, h2, full;
    h1   = sb.id_rs1_used & (sb.id_rs1 != '0) & (cnt[sb.id_rs1] != '0);
    h2   = sb.id_rs2_used & (sb.id_rs2 != '0) & (cnt[sb.id_rs2] != '0);
    full = sb.id_we & (sb.id_dest != '0) & (cnt[sb.id_dest] == cnt_t'(CNT_MAX));
    sb.stall_id = sb.id_valid & (h1 | h2 | full);
  end

  // Total follows the counters' effective moves so it always equals their sum.
  always_ff @(posedge clk) begin
    if (clr) total_q <= '0;
    else     total_q <= total_q + total_t'(|up_v) - total_t'(|dn_v);
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (reset)                                  err_q <= 1'b0;
    else if ((|err_v) | (sb.issue_fire & sb.stall_id)) err_q <= 1'b1;
  end

  assign sb.inflight_total = total_q;
  assign sb.sb_err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  reg_scoreboard_if sb_if ();

  reg_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.id_valid    = 1'b0;
    sb_if.id_rs1      = '0;
    sb_if.id_rs1_used = 1'b0;
    sb_if.id_rs2      = '0;
    sb_if.id_rs2_used = 1'b0;
    sb_if.id_we       = 1'b0;
    sb_if.id_dest     = '0;
    sb_if.issue_fire  = 1'b0;
    sb_if.wb_we       = 1'b0;
    sb_if.wb_waddr    = '0;
    sb_if.flush       = 1'b0;
  endtask

  // ID instruction writing dest, optionally accepted this cycle.
  task automatic id_write(input logic [4:0] dest, input logic fire);
    sb_if.id_valid   = 1'b1;
    sb_if.id_we      = 1'b1;
    sb_if.id_dest    = dest;
    sb_if.issue_fire = fire;
  endtask

  task automatic id_read(input logic [4:0] rs1);
    sb_if.id_valid    = 1'b1;
    sb_if.id_rs1      = rs1;
    sb_if.id_rs1_used = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(sb_if.stall_id), 0);
    chk("rst_total", 32'(sb_if.inflight_total), 0);
    chk("rst_err",   32'(sb_if.sb_err), 0);

    // 1: RAW on r5 held until WB commit, released the cycle after
    id_write(5'd5, 1'b1);
    #1 chk("t1_issue_stall", 32'(sb_if.stall_id), 0);
    tick();
    idle();
    id_read(5'd5);
    #1 chk("t1_raw_stall", 32'(sb_if.stall_id), 1);
    chk("t1_total1", 32'(sb_if.inflight_total), 1);
    tick();
    chk("t1_stall_hold", 32'(sb_if.stall_id), 1);
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd5;
    #1 chk("t1_stall_commit_cycle", 32'(sb_if.stall_id), 1);
    tick();
    sb_if.wb_we    = 1'b0;
    sb_if.wb_waddr = '0;
    #1 chk("t1_stall_release", 32'(sb_if.stall_id), 0);
    chk("t1_total0", 32'(sb_if.inflight_total), 0);

    // 2: simultaneous inc/dec on r7 leaves count unchanged
    idle();
    id_write(5'd7, 1'b1);
    tick();
    idle();
    id_write(5'd7, 1'b1);
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd7;
    tick();
    idle();
    chk("t2_total", 32'(sb_if.inflight_total), 1);
    id_read(5'd7);
    #1 chk("t2_r7_pending", 32'(sb_if.stall_id), 1);
    idle();
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd7;
    tick();
    idle();
    chk("t2_total0", 32'(sb_if.inflight_total), 0);
    chk("t2_err", 32'(sb_if.sb_err), 0);

    // 3: saturate r9, dest-full stall, forced issue flags error
    id_write(5'd9, 1'b1);
    tick();
    tick();
    #1 chk("t3_third_no_stall", 32'(sb_if.stall_id), 0);
    tick();
    chk("t3_total3", 32'(sb_if.inflight_total), 3);
    sb_if.issue_fire = 1'b0;
    #1 chk("t3_full_stall", 32'(sb_if.stall_id), 1);
    chk("t3_err_clean", 32'(sb_if.sb_err), 0);
    sb_if.issue_fire = 1'b1;
    tick();
    idle();
    chk("t3_total_held", 32'(sb_if.inflight_total), 3);
    chk("t3_err_set", 32'(sb_if.sb_err), 1);
    // mid-operation reset clears counts and error
    reset = 1'b1;
    tick();
    reset = 1'b0;
    id_read(5'd9);
    #1 chk("t3_rst_stall", 32'(sb_if.stall_id), 0);
    chk("t3_rst_total", 32'(sb_if.inflight_total), 0);
    chk("t3_rst_err", 32'(sb_if.sb_err), 0);

    // 4: r0 never stalls or counts
    idle();
    id_write(5'd0, 1'b1);
    sb_if.id_rs1_used = 1'b1;
    sb_if.id_rs2_used = 1'b1;
    #1 chk("t4_r0_stall", 32'(sb_if.stall_id), 0);
    tick();
    idle();
    chk("t4_r0_total", 32'(sb_if.inflight_total), 0);
    chk("t4_r0_err", 32'(sb_if.sb_err), 0);

    // different registers in one cycle: inc r11, dec r10
    id_write(5'd10, 1'b1);
    tick();
    idle();
    id_write(5'd11, 1'b1);
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd10;
    tick();
    idle();
    chk("t4b_total", 32'(sb_if.inflight_total), 1);
    id_read(5'd10);
    #1 chk("t4b_r10_free", 32'(sb_if.stall_id), 0);
    sb_if.id_rs1 = 5'd11;
    #1 chk("t4b_r11_busy", 32'(sb_if.stall_id), 1);
    idle();
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd11;
    tick();
    idle();
    chk("t4b_total0", 32'(sb_if.inflight_total), 0);

    // 5: flush discards pending and same-cycle issue
    id_write(5'd3, 1'b1);
    tick();
    id_write(5'd4, 1'b1);
    tick();
    chk("t5_total2", 32'(sb_if.inflight_total), 2);
    id_write(5'd6, 1'b1);
    sb_if.flush = 1'b1;
    tick();
    idle();
    chk("t5_flush_total", 32'(sb_if.inflight_total), 0);
    id_read(5'd3);
    #1 chk("t5_r3_free", 32'(sb_if.stall_id), 0);
    sb_if.id_rs1 = 5'd6;
    #1 chk("t5_r6_free", 32'(sb_if.stall_id), 0);
    chk("t5_err", 32'(sb_if.sb_err), 0);

    // 6: underflow on r12 sets error; reset clears it
    idle();
    sb_if.wb_we    = 1'b1;
    sb_if.wb_waddr = 5'd12;
    tick();
    idle();
    chk("t6_total", 32'(sb_if.inflight_total), 0);
    chk("t6_err_set", 32'(sb_if.sb_err), 1);
    id_read(5'd12);
    #1 chk("t6_r12_free", 32'(sb_if.stall_id), 0);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("t6_err_clr", 32'(sb_if.sb_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
